// File: rtl/srff_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : srff_pkg                                                       |
// | Brief   : Shared types and helpers for the SR flop-bank excitation       |
// |           driver: FSM state encoding, S/R pair encoding, per-bit         |
// |           excitation function.                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package srff_pkg;

  // Driver FSM states.
  typedef enum logic [1:0] {
    SRD_IDLE  = 2'd0,
    SRD_APPLY = 2'd1,
    SRD_CHECK = 2'd2
  } srd_state_e;

  // Excitation pair encoding, {s, r}.
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RST     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  // Excitation needed to move one flop from q_bit to target_bit.
  // Only SET, RST or HOLD can ever be returned, so the illegal pair is
  // structurally impossible downstream.
  function automatic logic [1:0] sr_excite(input logic target_bit, input logic q_bit);
    logic [1:0] pair;
    pair = SR_HOLD;
    if (target_bit && !q_bit) begin
      pair = SR_SET;
    end else if (!target_bit && q_bit) begin
      pair = SR_RST;
    end
    return pair;
  endfunction

endpackage : srff_pkg
`default_nettype wire

// File: rtl/srff_excite_drv_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : srff_excite_drv_if                                           |
// | Brief     : Target handshake, bank feedback and excitation/status bus    |
// |             between a requester/SR bank (master) and the driver (slave). |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface srff_excite_drv_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  tgt;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [W-1:0]  q_fb;
  logic [W-1:0]  s;
  logic [W-1:0]  r;
  logic [CW-1:0] chg_cnt;
  logic          done;
  logic          err;
  logic          err_flag;

  // Requester side together with the SR bank it fronts.
  modport master (
    output tgt, tgt_valid, q_fb,
    input  tgt_ready, s, r, chg_cnt, done, err, err_flag
  );

  // Excitation driver side.
  modport slave (
    input  tgt, tgt_valid, q_fb,
    output tgt_ready, s, r, chg_cnt, done, err, err_flag
  );

endinterface : srff_excite_drv_if
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : popcount                                                        |
// | Brief  : Combinational population count of a W-bit vector.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module popcount #(
  parameter int W = 8
) (
  input  wire logic [W-1:0]             vec_i,
  output logic      [$clog2(W+1)-1:0]   cnt_o
);

  localparam int CW = $clog2(W + 1);

  // Sum of set bits; a simple adder chain is adequate at these widths.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule : popcount
`default_nettype wire

// File: rtl/srff_excite_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : srff_excite_drv                                                 |
// | Brief  : Excitation driver for a bank of W positive-edge SR flops.      |
// |          Accepts a target word, drives one cycle of s/r computed from   |
// |          the bank feedback, verifies the result and re-applies up to    |
// |          MAX_RETRY times before flagging an error.                      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module srff_excite_drv
  import srff_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_RETRY = 2
) (
  input wire logic          clk,
  input wire logic          clear_n,
  srff_excite_drv_if.slave  bus
);

  localparam int         CW          = $clog2(W + 1);
  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

  srd_state_e    state_q,    state_d;
  logic [W-1:0]  tgt_q,      tgt_d;
  logic [2:0]    retry_q,    retry_d;
  logic [W-1:0]  s_q,        s_d;
  logic [W-1:0]  r_q,        r_d;
  logic [CW-1:0] chg_cnt_q,  chg_cnt_d;
  logic          done_q,     done_d;
  logic          err_q,      err_d;
  logic          err_flag_q, err_flag_d;

  logic [W-1:0]  ex_tgt_w;
  logic [W-1:0]  exc_s_w;
  logic [W-1:0]  exc_r_w;
  logic [CW-1:0] pop_w;
  logic          match_w;

  // The excitation source is the incoming word on accept and the latched
  // target on a re-apply; those are the only two states that load s/r.
  assign ex_tgt_w = (state_q == SRD_IDLE) ? bus.tgt : tgt_q;
  assign match_w  = (bus.q_fb == tgt_q);

  for (genvar gi = 0; gi < W; gi++) begin : g_excite
    logic [1:0] pair_w;
    assign pair_w      = sr_excite(ex_tgt_w[gi], bus.q_fb[gi]);
    // Decoding by exact code keeps s and r disjoint by construction.
    assign exc_s_w[gi] = (pair_w == SR_SET);
    assign exc_r_w[gi] = (pair_w == SR_RST);
  end

  popcount #(
    .W (W)
  ) u_popcount (
    .vec_i (ex_tgt_w ^ bus.q_fb),
    .cnt_o (pop_w)
  );

  // Next-state and registered-output logic; s/r and pulses default to zero
  // so excitation lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    retry_d    = retry_q;
    s_d        = '0;
    r_d        = '0;
    chg_cnt_d  = chg_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;

    case (state_q)
      SRD_IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d     = bus.tgt;
          s_d       = exc_s_w;
          r_d       = exc_r_w;
          chg_cnt_d = pop_w;
          retry_d   = '0;
          state_d   = SRD_APPLY;
        end
      end

      SRD_APPLY: begin
        // The bank samples the excitation on this edge; drop it afterwards.
        state_d = SRD_CHECK;
      end

      SRD_CHECK: begin
        if (match_w) begin
          done_d  = 1'b1;
          state_d = SRD_IDLE;
        end else if (retry_q < MAX_RETRY_C) begin
          s_d       = exc_s_w;
          r_d       = exc_r_w;
          chg_cnt_d = pop_w;
          retry_d   = retry_q + 3'd1;
          state_d   = SRD_APPLY;
        end else begin
          err_d      = 1'b1;
          err_flag_d = 1'b1;
          state_d    = SRD_IDLE;
        end
      end

      default: begin
        state_d = SRD_IDLE;
      end
    endcase
  end

  // State and output registers; clear_n discards any pending target at once.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= SRD_IDLE;
      tgt_q      <= '0;
      retry_q    <= '0;
      s_q        <= '0;
      r_q        <= '0;
      chg_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      retry_q    <= retry_d;
      s_q        <= s_d;
      r_q        <= r_d;
      chg_cnt_q  <= chg_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.tgt_ready = (state_q == SRD_IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.chg_cnt   = chg_cnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_flag  = err_flag_q;

endmodule : srff_excite_drv
`default_nettype wire

// File: tb/tb_srff_excite_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_srff_excite_drv                                              |
// | Brief  : Directed self-checking bench for srff_excite_drv with a        |
// |          behavioural SR flop bank that can hold bits stuck low.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_srff_excite_drv;

  localparam int W         = 8;
  localparam int MAX_RETRY = 2;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;

  srff_excite_drv_if #(.W(W)) bus ();

  srff_excite_drv #(
    .W         (W),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SR bank: q+ = s | (q & ~r); stuck_lo bits never capture a 1.
  logic [W-1:0] bank_q;
  logic [W-1:0] stuck_lo    = '0;
  logic [W-1:0] preload_val = '0;
  logic         preload_en  = 1'b0;

  // SR bank update with the same asynchronous clear as the driver.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)        bank_q <= '0;
    else if (preload_en) bank_q <= preload_val;
    else                 bank_q <= ((bank_q & ~bus.r) | bus.s) & ~stuck_lo;
  end

  assign bus.q_fb = bank_q;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int exc_cyc  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants and pulse/excitation tallies.
  always @(negedge clk) begin
    if (clear_n) begin
      check_eq("s_and_r_zero", 32'(bus.s & bus.r), 32'd0);
      check_eq("done_err_excl", 32'(bus.done & bus.err), 32'd0);
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
      if ((bus.s | bus.r) != '0) exc_cyc++;
    end
  end

  task automatic preload(input logic [W-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // Called at a negedge with the driver idle; returns one negedge after the
  // accepting edge (index 1).
  task automatic accept(input logic [W-1:0] t);
    bus.tgt       = t;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    bus.tgt       = '0;
  endtask

  // Walks negedges from index 'start' until done or err, bounded.
  task automatic await_result(input int start, output int idx,
                              output logic got_done, output logic got_err);
    int   n;
    logic seen;
    n        = start;
    seen     = 1'b0;
    idx      = -1;
    got_done = 1'b0;
    got_err  = 1'b0;
    while (!seen && n < start + 20) begin
      @(negedge clk);
      n++;
      if (bus.done || bus.err) begin
        seen     = 1'b1;
        idx      = n;
        got_done = bus.done;
        got_err  = bus.err;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   idx;
    logic gd, ge;
    int   snap_a, snap_b;

    bus.tgt       = '0;
    bus.tgt_valid = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check_eq("rst_s",        32'(bus.s), 32'h00);
    check_eq("rst_r",        32'(bus.r), 32'h00);
    check_eq("rst_chg",      32'(bus.chg_cnt), 32'd0);
    check_eq("rst_done",     32'(bus.done), 32'd0);
    check_eq("rst_err",      32'(bus.err), 32'd0);
    check_eq("rst_err_flag", 32'(bus.err_flag), 32'd0);
    check_eq("rst_ready",    32'(bus.tgt_ready), 32'd1);

    // Basic write: 00 -> A5
    preload(8'h00);
    accept(8'hA5);
    check_eq("basic_s",     32'(bus.s), 32'hA5);
    check_eq("basic_r",     32'(bus.r), 32'h00);
    check_eq("basic_chg",   32'(bus.chg_cnt), 32'd4);
    check_eq("basic_ready", 32'(bus.tgt_ready), 32'd0);
    @(negedge clk);
    check_eq("basic_s_drop", 32'(bus.s), 32'h00);
    await_result(2, idx, gd, ge);
    check_eq("basic_at",    32'(idx), 32'd3);
    check_eq("basic_done",  32'(gd), 32'd1);
    check_eq("basic_rdy2",  32'(bus.tgt_ready), 32'd1);
    check_eq("basic_bank",  32'(bank_q), 32'hA5);
    @(negedge clk);
    check_eq("basic_pulse", 32'(bus.done), 32'd0);

    // Mixed set/reset: F0 -> 3C, with a stray valid held while busy
    preload(8'hF0);
    accept(8'h3C);
    check_eq("mixed_s",   32'(bus.s), 32'h0C);
    check_eq("mixed_r",   32'(bus.r), 32'hC0);
    check_eq("mixed_chg", 32'(bus.chg_cnt), 32'd4);
    bus.tgt       = 8'hFF;
    bus.tgt_valid = 1'b1;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    bus.tgt       = '0;
    await_result(2, idx, gd, ge);
    check_eq("mixed_at",   32'(idx), 32'd3);
    check_eq("mixed_done", 32'(gd), 32'd1);
    check_eq("mixed_bank", 32'(bank_q), 32'h3C);
    @(negedge clk);

    // Stuck bit 3 on first apply only -> one retry, done at index 5
    preload(8'h00);
    stuck_lo = 8'h08;
    accept(8'h08);
    check_eq("recov_s1", 32'(bus.s), 32'h08);
    @(negedge clk);
    stuck_lo = 8'h00;
    check_eq("recov_bank_miss", 32'(bank_q), 32'h00);
    await_result(2, idx, gd, ge);
    check_eq("recov_at",      32'(idx), 32'd5);
    check_eq("recov_done",    32'(gd), 32'd1);
    check_eq("recov_errflag", 32'(bus.err_flag), 32'd0);
    check_eq("recov_bank",    32'(bank_q), 32'h08);
    @(negedge clk);

    // Bit 0 permanently stuck -> three applies, err at index 7
    preload(8'h00);
    stuck_lo = 8'h01;
    snap_a   = exc_cyc;
    accept(8'h01);
    await_result(1, idx, gd, ge);
    check_eq("exh_at",      32'(idx), 32'd7);
    check_eq("exh_err",     32'(ge), 32'd1);
    check_eq("exh_no_done", 32'(gd), 32'd0);
    check_eq("exh_errflag", 32'(bus.err_flag), 32'd1);
    @(negedge clk);
    check_eq("exh_applies",  32'(exc_cyc - snap_a), 32'd3);
    check_eq("exh_pulse",    32'(bus.err), 32'd0);
    check_eq("exh_flag_hold", 32'(bus.err_flag), 32'd1);
    stuck_lo = 8'h00;
    accept(8'h00);
    check_eq("exh2_chg", 32'(bus.chg_cnt), 32'd0);
    await_result(1, idx, gd, ge);
    check_eq("exh2_at",      32'(idx), 32'd3);
    check_eq("exh2_done",    32'(gd), 32'd1);
    check_eq("exh2_errflag", 32'(bus.err_flag), 32'd1);
    @(negedge clk);

    // Reset dropped during APPLY
    preload(8'h00);
    accept(8'hFF);
    check_eq("mid_s_pre", 32'(bus.s), 32'hFF);
    snap_a = done_cnt;
    snap_b = err_cnt;
    #2 clear_n = 1'b0;
    #1;
    check_eq("mid_s_async",   32'(bus.s), 32'h00);
    check_eq("mid_r_async",   32'(bus.r), 32'h00);
    check_eq("mid_ready",     32'(bus.tgt_ready), 32'd1);
    check_eq("mid_errflag",   32'(bus.err_flag), 32'd0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("mid_no_done", 32'(done_cnt - snap_a), 32'd0);
    check_eq("mid_no_err",  32'(err_cnt - snap_b), 32'd0);

    // Target equal to current bank contents
    preload(8'h5A);
    accept(8'h5A);
    check_eq("same_s",   32'(bus.s), 32'h00);
    check_eq("same_r",   32'(bus.r), 32'h00);
    check_eq("same_chg", 32'(bus.chg_cnt), 32'd0);
    await_result(1, idx, gd, ge);
    check_eq("same_at",   32'(idx), 32'd3);
    check_eq("same_done", 32'(gd), 32'd1);
    check_eq("same_bank", 32'(bank_q), 32'h5A);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_srff_excite_drv
`default_nettype wire
